// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared definitions for the debounce scan controller: scan FSM encoding,
// a constant-foldable clog2 helper and the default 25 MHz timing values.
package debounce_scan_ctrl_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

  localparam int DEF_NUM_SW       = 4;
  localparam int DEF_TICK_DIV     = 2500;
  localparam int DEF_STABLE_TICKS = 100;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_scan_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping around, and reports it both one-hot and as an index.
module debounce_scan_ctrl_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest request is the last write.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr) + off) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debouncer for NUM_SW switches: one scan pass per prescaled tick,
// per-channel stability counters, pending event flags and a valid/ready event port.
module debounce_scan_ctrl
  import debounce_scan_ctrl_pkg::*;
#(
  parameter int NUM_SW       = DEF_NUM_SW,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  localparam int CHW         = (clog2(NUM_SW) > 1) ? clog2(NUM_SW) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_SW-1:0] i_switch,
  output logic [NUM_SW-1:0] o_switch,
  output logic              o_event_valid,
  input  logic              i_event_ready,
  output logic [CHW-1:0]    o_event_id,
  output logic              o_event_press,
  output logic              o_overrun
);

  localparam int CNTW = clog2(STABLE_TICKS);
  localparam int PW   = (clog2(TICK_DIV) > 1) ? clog2(TICK_DIV) : 1;

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_TICKS - 1);
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CHW-1:0]  LAST_CH = CHW'(NUM_SW - 1);

  logic [NUM_SW-1:0] sync1, s_sw;
  logic [PW-1:0]     presc;
  logic              tick;
  scan_state_t       state, state_next;
  logic              scan_en, scan_last;
  logic [CHW-1:0]    ch;
  logic [CNTW-1:0]   cnt [NUM_SW];
  logic [NUM_SW-1:0] pend, dir;
  logic              agree, at_max, commit;
  logic [CHW-1:0]    rr_ptr, grant_idx;
  logic [NUM_SW-1:0] grant;
  logic              grant_any, load, take;

  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (i_rst) begin
      sync1 <= '0;
      s_sw  <= '0;
    end else begin
      sync1 <= i_switch;
      s_sw  <= sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || tick) presc <= '0;
    else               presc <= presc + PW'(1);
  end

  assign tick = (presc == PRE_MAX);

  // Scan FSM: state register / next state / outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (tick) state_next = S_SCAN;
      S_SCAN:  if (ch == LAST_CH) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    scan_en   = (state == S_SCAN);
    scan_last = scan_en && (ch == LAST_CH);
  end

  // Channel index sits at 0 while idle so a new pass always starts at channel 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || !scan_en || scan_last) ch <= '0;
    else                                ch <= ch + CHW'(1);
  end

  assign agree  = (s_sw[ch] == o_switch[ch]);
  assign at_max = (cnt[ch] == CNT_MAX);
  assign commit = scan_en && !agree && at_max;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the count array is cleared on reset because a stale count would shorten the first debounce after reset.
      for (int i = 0; i < NUM_SW; i++) cnt[i] <= '0;
    end else if (scan_en) begin
      if (agree || at_max) cnt[ch] <= '0;
      else                 cnt[ch] <= cnt[ch] + CNTW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       o_switch     <= '0;
    else if (commit) o_switch[ch] <= s_sw[ch];
  end

  debounce_scan_ctrl_rr_arbiter #(
    .N  (NUM_SW),
    .IW (CHW)
  ) u_rr_arbiter (
    .req       (pend),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign load = !o_event_valid || i_event_ready;
  assign take = load && grant_any;

  // A commit on the channel being granted this cycle wins: its flag is set again last.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend <= '0;
      dir  <= '0;
    end else begin
      if (take) pend <= pend & ~grant;
      if (commit) begin
        pend[ch] <= 1'b1;
        dir[ch]  <= s_sw[ch];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_overrun <= 1'b0;
    else       o_overrun <= commit && pend[ch] && !(take && (grant_idx == ch));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_event_valid <= 1'b0;
      o_event_id    <= '0;
      o_event_press <= 1'b0;
      rr_ptr        <= '0;
    end else if (load) begin
      o_event_valid <= grant_any;
      if (grant_any) begin
        o_event_id    <= grant_idx;
        o_event_press <= dir[grant_idx];
        rr_ptr        <= (grant_idx == LAST_CH) ? '0 : grant_idx + CHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed reset/press/bounce/backpressure/overrun steps,
// then random hold/glitch sequences scored against a per-channel expected-event model.
module tb_debounce_scan_ctrl;

  localparam int NUM_SW       = 4;
  localparam int TICK_DIV     = 8;
  localparam int STABLE_TICKS = 4;
  // Commit window for a clean edge: (STABLE_TICKS-1)*TICK_DIV+3 .. STABLE_TICKS*TICK_DIV+NUM_SW+2
  localparam int LAT_MIN = (STABLE_TICKS - 1) * TICK_DIV + 3;
  localparam int LAT_MAX = STABLE_TICKS * TICK_DIV + NUM_SW + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic       ev_valid, ev_ready, ev_press, overrun;
  logic [1:0] ev_id;

  always #5 clk = ~clk;

  debounce_scan_ctrl #(
    .NUM_SW       (NUM_SW),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_switch      (sw_in),
    .o_switch      (sw_out),
    .o_event_valid (ev_valid),
    .i_event_ready (ev_ready),
    .o_event_id    (ev_id),
    .o_event_press (ev_press),
    .o_overrun     (overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Handshake and overrun monitor, sampled on the falling edge.
  logic [2:0] obs_q[$];
  int         obs_t[$];
  int         rd_idx  = 0;
  int         ovr_cnt = 0;
  int         cyc_cnt = 0;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (ev_valid && ev_ready) begin
      obs_q.push_back({ev_id, ev_press});
      obs_t.push_back(cyc_cnt);
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  logic exp_q [NUM_SW][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_random_ready(input int n);
    for (int i = 0; i < n; i++) begin
      ev_ready = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
  endtask

  task automatic wait_switch(input logic [3:0] target, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cycles(1);
      if (sw_out === target) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int new_events();
    return obs_q.size() - rd_idx;
  endfunction

  task automatic next_event(output logic [1:0] id, output logic press, output int t);
    id = 2'bxx;
    press = 1'bx;
    t = -1;
    if (rd_idx < obs_q.size()) begin
      {id, press} = obs_q[rd_idx];
      t = obs_t[rd_idx];
      rd_idx++;
    end
  endtask

  task automatic score_events();
    logic [1:0] id;
    logic       press;
    int         t;
    logic       want;
    while (rd_idx < obs_q.size()) begin
      next_event(id, press, t);
      check("rnd_evt_expected", 32'(exp_q[id].size() > 0), 1);
      if (exp_q[id].size() > 0) begin
        want = exp_q[id].pop_front();
        check("rnd_evt_press", press, want);
      end
    end
  endtask

  initial begin
    int         n, t, t_prev, ovr0;
    logic [1:0] id;
    logic       press;
    logic [3:0] base, nv, mask;

    // Reset with all switches high
    rst = 1'b1; sw_in = 4'hF; ev_ready = 1'b1;
    cycles(3);
    check("rst_switch",  sw_out,   0);
    check("rst_valid",   ev_valid, 0);
    check("rst_id",      ev_id,    0);
    check("rst_press",   ev_press, 0);
    check("rst_overrun", overrun,  0);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cycles(1);
      check("rst_hold_switch", sw_out, 0);
    end
    wait_switch(4'hF, 40, n);
    check("rst_then_commit", 32'(n > 0), 1);
    rst = 1'b1; sw_in = 4'h0;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    rd_idx = obs_q.size();

    // Clean press and release on channel 2
    cycles($urandom_range(0, 7));
    sw_in = 4'h4;
    wait_switch(4'h4, 45, n);
    check("press_latency_ok", 32'(n >= LAT_MIN && n <= LAT_MAX), 1);
    cycles(6);
    check("press_evt_count", new_events(), 1);
    next_event(id, press, t);
    check("press_evt_id", id, 2);
    check("press_evt_dir", press, 1);
    sw_in = 4'h0;
    wait_switch(4'h0, 45, n);
    check("release_latency_ok", 32'(n >= LAT_MIN && n <= LAT_MAX), 1);
    cycles(6);
    check("release_evt_count", new_events(), 1);
    next_event(id, press, t);
    check("release_evt_id", id, 2);
    check("release_evt_dir", press, 0);

    // Bouncing channel 1 never commits
    for (int i = 0; i < 20; i++) begin
      sw_in[1] = ~sw_in[1];
      cycles(10);
      check("bounce_switch1", sw_out[1], 0);
    end
    sw_in = 4'h0;
    cycles(45);
    check("bounce_final", sw_out, 0);
    check("bounce_no_evt", new_events(), 0);

    // All four channels pressed together straight out of reset
    rst = 1'b1;
    cycles(2);
    rst = 1'b0; sw_in = 4'hF;
    rd_idx = obs_q.size();
    wait_switch(4'hF, 45, n);
    check("simul_commit", 32'(n > 0), 1);
    cycles(6);
    check("simul_evt_count", new_events(), 4);
    t_prev = -1;
    for (int k = 0; k < 4; k++) begin
      next_event(id, press, t);
      check("simul_id", id, k);
      check("simul_dir", press, 1);
      if (k > 0) check("simul_consecutive", t - t_prev, 1);
      t_prev = t;
    end

    // Backpressure holds the first event; round robin then serves channel 0
    rst = 1'b1; sw_in = 4'h0; ev_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    rd_idx = obs_q.size();
    sw_in = 4'h8;
    wait_switch(4'h8, 45, n);
    check("bp_commit3", 32'(n > 0), 1);
    cycles(3);
    check("bp_valid", ev_valid, 1);
    check("bp_id", ev_id, 3);
    check("bp_press", ev_press, 1);
    sw_in = 4'h9;
    wait_switch(4'h9, 45, n);
    check("bp_commit0", 32'(n > 0), 1);
    cycles(3);
    check("bp_valid_held", ev_valid, 1);
    check("bp_id_held", ev_id, 3);
    check("bp_press_held", ev_press, 1);
    check("bp_no_handshake", new_events(), 0);
    ev_ready = 1'b1;
    cycles(4);
    check("bp_evt_count", new_events(), 2);
    next_event(id, press, t);
    check("bp_first_id", id, 3);
    next_event(id, press, t);
    check("bp_second_id", id, 0);
    check("bp_second_dir", press, 1);

    // Overrun on channel 1 while the output register is occupied, then reset mid-handshake
    rst = 1'b1; sw_in = 4'h0; ev_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    ovr0 = ovr_cnt;
    sw_in = 4'h1;
    wait_switch(4'h1, 45, n);
    sw_in = 4'h3;
    wait_switch(4'h3, 45, n);
    sw_in = 4'h1;
    wait_switch(4'h1, 45, n);
    check("ovr_release_commit", 32'(n > 0), 1);
    cycles(3);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("ovr_held_id", ev_id, 0);
    ev_ready = 1'b1;
    cycles(1);
    ev_ready = 1'b0;
    check("ovr_queued_valid", ev_valid, 1);
    check("ovr_queued_id", ev_id, 1);
    check("ovr_queued_press", ev_press, 0);
    rst = 1'b1; sw_in = 4'h0;
    cycles(1);
    check("ovr_rst_valid", ev_valid, 0);
    rst = 1'b0; ev_ready = 1'b1;
    rd_idx = obs_q.size();
    cycles(60);
    check("ovr_rst_no_evt", new_events(), 0);
    check("ovr_rst_switch", sw_out, 0);

    // Random holds and sub-threshold glitches against the expected-event model
    rst = 1'b1; sw_in = 4'h0;
    cycles(2);
    rst = 1'b0;
    rd_idx = obs_q.size();
    ovr0 = ovr_cnt;
    base = 4'h0;
    for (int step = 0; step < 40; step++) begin
      if ($urandom_range(0, 2) == 0) begin
        // Glitch of at most 24 cycles spans at most three scans of any channel
        mask = 4'($urandom_range(1, 15));
        sw_in = base ^ mask;
        run_random_ready($urandom_range(1, 24));
        sw_in = base;
        run_random_ready($urandom_range(10, 20));
        check("rnd_glitch_switch", sw_out, base);
      end else begin
        nv = 4'($urandom_range(0, 15));
        for (int c = 0; c < NUM_SW; c++) begin
          if (nv[c] != base[c]) exp_q[c].push_back(nv[c]);
        end
        sw_in = nv;
        run_random_ready($urandom_range(40, 60));
        check("rnd_hold_switch", sw_out, nv);
        base = nv;
      end
      score_events();
    end
    ev_ready = 1'b1;
    cycles(10);
    score_events();
    for (int c = 0; c < NUM_SW; c++) begin
      check("rnd_leftover", exp_q[c].size(), 0);
    end
    check("rnd_no_overrun", ovr_cnt - ovr0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
